// File: rtl/stump_alu_mc_pkg.sv
// rtl/stump_alu_mc_pkg.sv - shared func codes, flag indices and FSM states for stump_alu_mc
package stump_alu_mc_pkg;

    typedef enum logic [2:0] {
        FN_ADD  = 3'b000,
        FN_ADC  = 3'b001,
        FN_SUB  = 3'b010,
        FN_SBC  = 3'b011,
        FN_AND  = 3'b100,
        FN_OR   = 3'b101,
        FN_LDST = 3'b110,
        FN_BCC  = 3'b111
    } func_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/stump_alu_comb.sv
// rtl/stump_alu_comb.sv - combinational Stump result/flags unit
// Ports: a, b operands; func 3-bit Stump code; c_in current C flag; csh shifter carry;
//        result ALU result; flags {N,Z,V,C}; flags_we flags write-back request.
module stump_alu_comb
    import stump_alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       func,
    input  logic             c_in,
    input  logic             csh,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             flags_we
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_op;
    logic             cin_op;

    always_comb begin
        b_op   = b;
        cin_op = 1'b0;
        // Subtracts reuse the adder with inverted B; the carry-in supplies the +1 / ~c_in.
        case (func_e'(func))
            FN_ADC: cin_op = c_in;
            FN_SUB: begin
                b_op   = ~b;
                cin_op = 1'b1;
            end
            FN_SBC: begin
                b_op   = ~b;
                cin_op = ~c_in;
            end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};
    end

    always_comb begin
        result   = sum[WIDTH-1:0];
        flags    = 4'b0000;
        flags_we = 1'b1;
        case (func_e'(func))
            FN_ADD, FN_ADC: begin
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            FN_SUB, FN_SBC: begin
                // C holds borrow, i.e. the inverted adder carry.
                flags[FLAG_C] = ~sum[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            FN_AND: begin
                result        = a & b;
                flags[FLAG_C] = csh;
            end
            FN_OR: begin
                result        = a | b;
                flags[FLAG_C] = csh;
            end
            default: flags_we = 1'b0;   // address calculation leaves flags untouched
        endcase
        if (flags_we) begin
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/stump_alu_mc.sv
// rtl/stump_alu_mc.sv - multi-cycle Stump ALU with shift-add multiply and valid/ready handshake
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake; operand_a,
//        operand_b, func, mul_en, c_in, csh sampled at accept; out_valid/out_ready result
//        handshake; result, flags_out {N,Z,V,C}, flags_we held while stalled.
module stump_alu_mc
    import stump_alu_mc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       func,
    input  logic             mul_en,
    input  logic             c_in,
    input  logic             csh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic             flags_we
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               flags_we_q, flags_we_d;

    logic [WIDTH-1:0]   comb_result;
    logic [3:0]         comb_flags;
    logic               comb_we;
    logic [2*WIDTH-1:0] acc_sum;
    logic               accept;
    logic               mul_sel;

    stump_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (operand_a),
        .b        (operand_b),
        .func     (func),
        .c_in     (c_in),
        .csh      (csh),
        .result   (comb_result),
        .flags    (comb_flags),
        .flags_we (comb_we)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        flags_we_d  = flags_we_q;

        in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        mul_sel  = (MUL_EN != 0) && mul_en;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (mul_sel) begin
                state_d  = ST_MUL;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, operand_a};
                mplier_d = operand_b;
            end else begin
                // A completing op overrides the drain above, so out_valid stays high.
                out_valid_d = 1'b1;
                result_d    = comb_result;
                flags_d     = comb_flags;
                flags_we_d  = comb_we;
            end
        end

        if (state_q == ST_MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d             = ST_IDLE;
                out_valid_d         = 1'b1;
                result_d            = acc_sum[WIDTH-1:0];
                flags_d             = 4'b0000;
                flags_d[FLAG_N]     = acc_sum[WIDTH-1];
                flags_d[FLAG_Z]     = (acc_sum[WIDTH-1:0] == '0);
                flags_d[FLAG_C]     = |acc_sum[2*WIDTH-1:WIDTH];
                flags_we_d          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            flags_we_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            flags_we_q  <= flags_we_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags_out = flags_q;
    assign flags_we  = flags_we_q;

endmodule

// File: doc/stump_alu_mc.md
Name: stump_alu_mc

Overview:
Parametrised, multi-cycle successor to the Stump combinational ALU. It keeps the eight 3-bit Stump function codes and their flag semantics, and adds the following:
- an iterative shift-add multiply mode;
- a valid/ready handshake on input and output;
- a registered output stage with backpressure.

It sits between operand fetch/shifter and the register/flag write-back in the Stump datapath. It is also usable as a stand-alone execute unit with stall support.

Parameters:
WIDTH, 16, datapath width in bits (>=4).
MUL_EN, 1, when 0 the multiply logic is not built and mul_en is ignored (the op is treated as func decode).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operation request.
in_ready  out  1  block can accept an operation this cycle.
operand_a  in  WIDTH  first operand.
operand_b  in  WIDTH  second operand (post-shifter).
func  in  3  Stump function code.
mul_en  in  1  1 = multiply (func ignored).
c_in  in  1  current C flag.
csh  in  1  carry from shifter.
out_valid  out  1  result/flags valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  ALU result.
flags_out  out  4  {N,Z,V,C}.
flags_we  out  1  flags must be written back with this result.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; out_valid=0; result=0; flags_out=0000; flags_we=0.
  - Multiply counter and accumulator cleared.
  - An in-flight multiply is aborted and its result discarded.
- Accept:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An op is accepted on a rising edge with in_valid && in_ready.
  - Operands, func, c_in and csh are sampled only at accept; later changes are ignored.
- Simple ops (mul_en=0):
  - Computed combinationally from the sampled inputs and registered at the accept edge.
  - out_valid is high from that edge: latency 1, throughput 1 per cycle.
- Functions and flags (computed at full WIDTH with a WIDTH+1-bit carry chain):
  - 000 ADD: A+B. C = carry-out. V = both operands same sign and result sign differs.
  - 001 ADC: A+B+c_in. Flags as ADD.
  - 010 SUB: A+~B+1. C = NOT carry-out (borrow). V = operand signs differ and result sign differs from A.
  - 011 SBC: A+~B+~c_in. Flags as SUB.
  - 100 AND / 101 OR: V=0, C=csh.
  - For 000-101: N=result[WIDTH-1], Z=(result==0), flags_we=1.
  - 110/111 (load-store/branch address): A+B, flags_out=0000, flags_we=0.
- Multiply (mul_en=1, MUL_EN=1):
  - The accept edge loads the multiplicand, the multiplier and a 2*WIDTH accumulator, and enters state MUL.
  - Each of WIDTH cycles: if multiplier lsb is set, add multiplicand<<i; then shift.
  - The WIDTH-th edge after accept writes the output register and returns to IDLE.
  - result = low WIDTH bits.
  - Flags: N=result[WIDTH-1], Z=(low==0), V=0, C=|high half, flags_we=1.
  - in_ready=0 throughout MUL.
  - The output stage is always empty during MUL, because accept required that the output be drained.
- Output hold:
  - While out_valid && !out_ready, result, flags_out and flags_we are stable.
  - out_valid falls on an edge with out_ready=1 and no new op completing.
  - Simultaneous drain and accept: the new result replaces the old one and out_valid stays 1.
- States: IDLE -> MUL (accept with mul_en); MUL -> IDLE (counter == WIDTH-1); any state -> IDLE on reset.

Decomposition:
- The shared package/definitions file holds:
  - the func codes (ADD, ADC, SUB, SBC, AND, OR, LDST, BCC);
  - the flag bit indices N=3, Z=2, V=1, C=0;
  - the state encoding IDLE/MUL.
- One sub-module: stump_alu_comb. It is the parametrised combinational result/flags unit (WIDTH), instantiated once. The top level holds the handshake, the output register and the multiply FSM.

Test Plan:
1. ADD A=0x7FFF, B=0x0001 -> result 0x8000, flags 1010, flags_we=1, out_valid 1 cycle after accept.
2. SUB A=0x0001, B=0x0002 -> 0xFFFF, flags 1001. Then SBC A=0x0005, B=0x0003, c_in=1 -> 0x0001, flags 0000.
3. MUL A=0x0100, B=0x0100 -> result 0x0000, flags 0101. in_ready=0 for 16 cycles; out_valid asserted 16 edges after accept.
4. Backpressure: out_ready=0 for 5 cycles with in_valid held -> result/flags stable, in_ready=0, no second accept. Releasing out_ready -> next result valid the following cycle with no gap or duplicate.
5. rst_n low at cycle 8 of a MUL -> out_valid=0, flags 0000 immediately. After release in_ready=1, and a following ADD 0x0002+0x0003 returns 0x0005, flags 0000.
6. AND A=0xF0F0, B=0x0FF0, csh=1 -> 0x00F0, flags 0001. Then func 110, A=0x0010, B=0x0004 -> 0x0014, flags_we=0.
